// File: rtl/cmos_inv_pkg.sv
// Shared types and helpers for the conditional-inversion pipeline:
// the per-word mode encoding and the per-stage invert decision.
package cmos_inv_pkg;

  typedef enum logic [1:0] {
    PASS      = 2'd0,
    INV_FIRST = 2'd1,
    INV_EVERY = 2'd2,
    INV_LAST  = 2'd3
  } inv_mode_e;

  function automatic logic inv_at_stage(input inv_mode_e mode,
                                        input int unsigned k,
                                        input int unsigned depth);
    logic inv;
    case (mode)
      INV_FIRST: inv = (k == 0);
      INV_EVERY: inv = 1'b1;
      INV_LAST:  inv = (k == depth - 1);
      default:   inv = 1'b0;
    endcase
    return inv;
  endfunction

endpackage

// File: rtl/cmos_inv_vec.sv
// WIDTH-bit bank of switch-level CMOS inverters (pmos pull-up, nmos pull-down).
// Only compiled when CMOS_INV_PIPE_SWITCH_LEVEL_EN is defined.
`ifdef CMOS_INV_PIPE_SWITCH_LEVEL_EN
module cmos_inv_vec #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            [WIDTH-1:0] a,
  output wire logic       [WIDTH-1:0] y
);

  supply1 vdd;
  supply0 gnd;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    pmos p_up (y[i], vdd, a[i]);
    nmos n_dn (y[i], gnd, a[i]);
  end

endmodule
`endif

// File: rtl/cmos_inv_pipe.sv
// WIDTH-bit, DEPTH-stage elastic pipeline with per-word conditional inversion.
// Define CMOS_INV_PIPE_SWITCH_LEVEL_EN to build inverters from cmos_inv_vec cells.
module cmos_inv_pipe
  import cmos_inv_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] level
);

  logic      [DEPTH-1:0] v;
  logic      [WIDTH-1:0] d [DEPTH];
  inv_mode_e             m [DEPTH];

  logic      [DEPTH-1:0] adv;
  logic      [DEPTH-1:0] load;
  logic      [DEPTH:0]   can_take;
  logic      [WIDTH-1:0] nxt_d [DEPTH];
  inv_mode_e             nxt_m [DEPTH];

  // can_take[k]: stage k is free or vacates this cycle; ripples back from out_ready
  always_comb begin
    adv             = '0;
    can_take        = '0;
    can_take[DEPTH] = out_ready;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      int unsigned k;
      k           = DEPTH - 1 - i;
      adv[k]      = v[k] & can_take[k+1];
      can_take[k] = ~v[k] | adv[k];
    end
  end

  assign in_ready = can_take[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic [WIDTH-1:0] src_d;
    inv_mode_e        src_m;
    logic             inv_sel;

    if (k == 0) begin : g_head
      assign src_d   = in_data;
      assign src_m   = inv_mode_e'(in_mode);
      assign load[k] = in_valid & in_ready;
    end else begin : g_body
      assign src_d   = d[k-1];
      assign src_m   = m[k-1];
      assign load[k] = adv[k-1];
    end

    assign inv_sel  = inv_at_stage(src_m, k, DEPTH);
    assign nxt_m[k] = src_m;

`ifdef CMOS_INV_PIPE_SWITCH_LEVEL_EN
    logic [WIDTH-1:0] inv_d;
    cmos_inv_vec #(.WIDTH(WIDTH)) u_inv (
      .a(src_d),
      .y(inv_d)
    );
    assign nxt_d[k] = inv_sel ? inv_d : src_d;
`else
    assign nxt_d[k] = inv_sel ? ~src_d : src_d;
`endif
  end

  logic acc_hs;
  logic out_hs;
  assign acc_hs = in_valid & in_ready;
  assign out_hs = v[DEPTH-1] & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v     <= '0;
      level <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        d[i] <= '0;
        m[i] <= PASS;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (load[i]) begin
          v[i] <= 1'b1;
          d[i] <= nxt_d[i];
          m[i] <= nxt_m[i];
        end else if (adv[i]) begin
          v[i] <= 1'b0;
        end
      end
      case ({acc_hs, out_hs})
        2'b10:   level <= level + CNT_W'(1);
        2'b01:   level <= level - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  // Last-stage mode is held for uniformity with the other stages but never consumed.
  logic tail_mode_unused;
  assign tail_mode_unused = ^m[DEPTH-1];

endmodule

// File: tb/tb_cmos_inv_pipe.sv
// Scoreboard bench for cmos_inv_pipe: a DEPTH=4/WIDTH=8 instance plus a DEPTH=1/WIDTH=1 instance.
module tb_cmos_inv_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] level;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] in_data1;
  logic [1:0] in_mode1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] out_data1;
  logic [0:0] level1;

  always #5 clk = ~clk;

  cmos_inv_pipe #(.WIDTH(8), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .level(level)
  );

  cmos_inv_pipe #(.WIDTH(1), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_mode(in_mode1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .level(level1)
  );

  typedef struct {
    logic [7:0]  d;
    int unsigned acc;
    bit          lat;
  } exp_t;

  exp_t        q  [$];
  exp_t        q1 [$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  bit          rnd   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: count inversions a word receives over DEPTH stages.
  function automatic logic [7:0] model(input logic [7:0] x, input logic [1:0] md, input int unsigned depth);
    case (md)
      2'd0:    return x;
      2'd2:    return (depth % 2 == 1) ? ~x : x;
      default: return ~x;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("unexpected_out", {24'd0, out_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("out_data", {24'd0, out_data}, {24'd0, e.d});
        if (e.lat) check("latency", cyc + 1 - e.acc, 4);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid1 && out_ready1) begin
      if (q1.size() == 0) begin
        check("unexpected_out1", {31'd0, out_data1}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("out_data1", {31'd0, out_data1}, {31'd0, e.d[0]});
        check("latency1", cyc + 1 - e.acc, 1);
      end
    end
  end

  task automatic send(input logic [7:0] dat, input logic [1:0] md, input logic [7:0] e, input bit lat);
    int unsigned t = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = dat;
    in_mode  = md;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) q.push_back('{d: e, acc: cyc + 1, lat: lat});
      @(posedge clk);
      #1;
      t++;
      if (rnd) out_ready = ($urandom % 4) != 0;
    end
    in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send1(input logic dat, input logic [1:0] md, input logic e);
    int unsigned t = 0;
    bit acc = 1'b0;
    in_valid1 = 1'b1;
    in_data1  = dat;
    in_mode1  = md;
    while (!acc && t < 20) begin
      @(negedge clk);
      acc = in_ready1;
      if (acc) q1.push_back('{d: {7'd0, e}, acc: cyc + 1, lat: 1'b1});
      @(posedge clk);
      #1;
      t++;
    end
    in_valid1 = 1'b0;
    if (!acc) check("send1_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_empty();
    int unsigned t = 0;
    while ((q.size() != 0 || q1.size() != 0) && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_empty", q.size() + q1.size(), 0);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_mode    = '0;
    out_ready  = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    in_mode1   = '0;
    out_ready1 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_level", {29'd0, level}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // three words in flight, then reset discards them
    send(8'h11, 2'd0, 8'h11, 1'b0);
    send(8'h22, 2'd1, 8'hDD, 1'b0);
    send(8'h33, 2'd3, 8'hCC, 1'b0);
    check("pre_rst_level", {29'd0, level}, 3);
    rst_n = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_level", {29'd0, level}, 0);
    check("midrst_out_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;

    // back-to-back stream, one of each mode
    out_ready = 1'b1;
    send(8'hA5, 2'd0, 8'hA5, 1'b1);
    send(8'hA5, 2'd1, 8'h5A, 1'b1);
    send(8'h0F, 2'd2, 8'h0F, 1'b1);
    send(8'h3C, 2'd3, 8'hC3, 1'b1);
    wait_empty();

    // stall: fill to four, fifth is refused, then drain
    out_ready = 1'b0;
    send(8'h01, 2'd0, 8'h01, 1'b0);
    send(8'h02, 2'd1, 8'hFD, 1'b0);
    send(8'h04, 2'd2, 8'h04, 1'b0);
    send(8'h08, 2'd3, 8'hF7, 1'b0);
    check("full_level", {29'd0, level}, 4);
    in_valid = 1'b1;
    in_data  = 8'h10;
    in_mode  = 2'd0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("full_in_ready", {31'd0, in_ready}, 0);
      check("full_hold_data", {24'd0, out_data}, 32'h01);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_level", {29'd0, level}, 32'(4 - i));
      @(posedge clk);
      #1;
    end

    // full pipeline streaming: accept and emit every cycle
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 2'd1, ~8'(8'h40 + i), 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h80 + i * 3), 2'(i % 4), model(8'(8'h80 + i * 3), 2'(i % 4), 4), 1'b0);
      check("stream_level", {29'd0, level}, 4);
      check("stream_out_valid", {31'd0, out_valid}, 1);
    end
    wait_empty();

    // DEPTH=1, WIDTH=1 instance
    send1(1'b1, 2'd2, 1'b0);
    send1(1'b1, 2'd3, 1'b0);
    send1(1'b1, 2'd1, 1'b0);
    send1(1'b1, 2'd0, 1'b1);
    send1(1'b0, 2'd2, 1'b1);
    wait_empty();

    // random traffic with random stalls against the reference model
    rnd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] x;
      logic [1:0] md;
      x  = 8'($urandom);
      md = 2'($urandom);
      send(x, md, model(x, md, 4), 1'b0);
      if ($urandom % 5 == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom % 4) != 0;
      end
    end
    rnd       = 1'b0;
    out_ready = 1'b1;
    wait_empty();
    @(negedge clk);
    check("final_level", {29'd0, level}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
